// File: rtl/vu_envelope_detector.sv
// vu_envelope_detector: stereo full-wave rectifier with instant attack, linear decay and registered 8-bit VU levels.
// Optional per-channel peak hold is enabled by defining VU_PEAK_HOLD_EN.
module vu_envelope_detector #(
    parameter int SAMPLE_W     = 24,
    parameter int DECAY_DIV    = 96,
    parameter int DECAY_STEP   = 1,
    parameter int HOLD_SAMPLES = 4800
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       audio_clk_enable,
    input  logic                       audio_enable,
    input  logic signed [SAMPLE_W-1:0] l_sample,
    input  logic signed [SAMPLE_W-1:0] r_sample,
    output logic [7:0]                 l_level,
    output logic [7:0]                 r_level,
    output logic                       level_valid
);
    localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);
    localparam logic [7:0] STEP = 8'(DECAY_STEP);

    typedef enum logic [1:0] {IDLE, PROC_L, PROC_R, UPDATE} state_t;

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] l_smp_q, l_smp_d, r_smp_q, r_smp_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_q, tick_d;
    logic [7:0]          l_env_q, l_env_d, r_env_q, r_env_d;
    logic [7:0]          l_lvl_q, l_lvl_d, r_lvl_q, r_lvl_d;
    logic                valid_q, valid_d;
    logic [7:0]          l_mag, r_mag;
    logic                l_att, r_att, l_dec, r_dec;

    // The most negative sample negates to itself, so a set MSB after abs means full scale.
    function automatic logic [7:0] rect(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] a;
        a = s[SAMPLE_W-1] ? -s : s;
        return a[SAMPLE_W-1] ? 8'hFF : 8'(a >> (SAMPLE_W - 9));
    endfunction

    function automatic logic [7:0] decay(input logic [7:0] env);
        return (env > STEP) ? env - STEP : 8'd0;
    endfunction

    assign l_mag = rect(l_smp_q);
    assign r_mag = rect(r_smp_q);
    assign l_att = l_mag >= l_env_q;
    assign r_att = r_mag >= r_env_q;

`ifdef VU_PEAK_HOLD_EN
    localparam int HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_SAMPLES);

    logic [HOLD_W-1:0] l_hold_q, l_hold_d, r_hold_q, r_hold_d;

    // Each channel's hold counter advances once per frame, in that channel's processing slot.
    always_comb begin
        l_hold_d = l_hold_q;
        r_hold_d = r_hold_q;
        if (state_q == PROC_L)
            l_hold_d = l_att ? '0 : (l_hold_q == HOLD_MAX) ? l_hold_q : l_hold_q + 1'b1;
        if (state_q == PROC_R)
            r_hold_d = r_att ? '0 : (r_hold_q == HOLD_MAX) ? r_hold_q : r_hold_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            l_hold_q <= '0;
            r_hold_q <= '0;
        end else begin
            l_hold_q <= l_hold_d;
            r_hold_q <= r_hold_d;
        end

    assign l_dec = tick_q && (l_hold_q == HOLD_MAX);
    assign r_dec = tick_q && (r_hold_q == HOLD_MAX);
`else
    assign l_dec = tick_q;
    assign r_dec = tick_q;
`endif

    always_comb begin
        state_d = state_q;
        l_smp_d = l_smp_q;
        r_smp_d = r_smp_q;
        div_d   = div_q;
        tick_d  = tick_q;
        l_env_d = l_env_q;
        r_env_d = r_env_q;
        l_lvl_d = l_lvl_q;
        r_lvl_d = r_lvl_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (audio_clk_enable) begin
                state_d = PROC_L;
                l_smp_d = audio_enable ? l_sample : '0;
                r_smp_d = audio_enable ? r_sample : '0;
                tick_d  = div_q == DIV_LAST;
                div_d   = tick_d ? '0 : div_q + 1'b1;
            end
            PROC_L: begin
                state_d = PROC_R;
                l_env_d = l_att ? l_mag : l_dec ? decay(l_env_q) : l_env_q;
            end
            PROC_R: begin
                state_d = UPDATE;
                r_env_d = r_att ? r_mag : r_dec ? decay(r_env_q) : r_env_q;
            end
            UPDATE: begin
                state_d = IDLE;
                l_lvl_d = l_env_q;
                r_lvl_d = r_env_q;
                valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            l_smp_q <= '0;
            r_smp_q <= '0;
            div_q   <= '0;
            tick_q  <= 1'b0;
            l_env_q <= '0;
            r_env_q <= '0;
            l_lvl_q <= '0;
            r_lvl_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            l_smp_q <= l_smp_d;
            r_smp_q <= r_smp_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            l_env_q <= l_env_d;
            r_env_q <= r_env_d;
            l_lvl_q <= l_lvl_d;
            r_lvl_q <= r_lvl_d;
            valid_q <= valid_d;
        end

    assign l_level     = l_lvl_q;
    assign r_level     = r_lvl_q;
    assign level_valid = valid_q;
endmodule

// File: tb/tb_vu_envelope_detector.sv
// tb_vu_envelope_detector: table vectors, scoreboard on level_valid, and hand-written frame corner cases.
module tb_vu_envelope_detector;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         ace = 1'b0;
    logic         aen = 1'b1;
    logic [W-1:0] ls = '0;
    logic [W-1:0] rs = '0;
    logic [7:0]   l_level, r_level;
    logic         level_valid;

    int tests = 0;
    int fails = 0;
    int vcount = 0;
    int v0;

    typedef struct {logic [7:0] l; logic [7:0] r;} exp_t;
    typedef struct {logic [W-1:0] l; logic [W-1:0] r; logic en; logic [7:0] el; logic [7:0] er;} vec_t;

    exp_t sb[$];
    vec_t vt[8];

    vu_envelope_detector dut (
        .clk(clk),
        .reset_n(reset_n),
        .audio_clk_enable(ace),
        .audio_enable(aen),
        .l_sample(ls),
        .r_sample(rs),
        .l_level(l_level),
        .r_level(r_level),
        .level_valid(level_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every level_valid pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && level_valid) begin
            vcount++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_valid: got l=%h r=%h with no frame pending", l_level, r_level);
            end else begin
                e = sb.pop_front();
                chk("sb_l", {24'd0, l_level}, {24'd0, e.l});
                chk("sb_r", {24'd0, r_level}, {24'd0, e.r});
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        ace = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic strobe(input logic [W-1:0] l, input logic [W-1:0] r, input logic en,
                          input logic [7:0] el, input logic [7:0] er);
        @(negedge clk);
        ls = l;
        rs = r;
        aen = en;
        ace = 1'b1;
        sb.push_back('{el, er});
        @(negedge clk);
        ace = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        vt[0] = '{24'h000000, 24'h000000, 1'b1, 8'h00, 8'h00};
        vt[1] = '{24'h400000, 24'h000000, 1'b1, 8'h80, 8'h00};
        vt[2] = '{24'h000000, 24'hFF8000, 1'b1, 8'h80, 8'h01};
        vt[3] = '{24'h200000, 24'h00FFFF, 1'b1, 8'h80, 8'h01};
        vt[4] = '{24'hC00000, 24'h008000, 1'b1, 8'h80, 8'h01};
        vt[5] = '{24'hA00000, 24'h123456, 1'b1, 8'hC0, 8'h24};
        vt[6] = '{24'h7FFFFF, 24'h7FFFFF, 1'b0, 8'hC0, 8'h24};
        vt[7] = '{24'h800000, 24'h800001, 1'b1, 8'hFF, 8'hFF};

        do_reset();
        chk("rst_l", {24'd0, l_level}, 32'h0);
        chk("rst_r", {24'd0, r_level}, 32'h0);
        chk("rst_valid", {31'd0, level_valid}, 32'h0);

        // Latency: levels move on the third edge after the strobe edge.
        v0 = vcount;
        @(negedge clk);
        ls = 24'h400000;
        rs = 24'h000000;
        aen = 1'b1;
        ace = 1'b1;
        sb.push_back('{8'h80, 8'h00});
        @(posedge clk);
        #1 ace = 1'b0;
        chk("lat_e0_l", {24'd0, l_level}, 32'h0);
        @(posedge clk);
        #1 chk("lat_e1_l", {24'd0, l_level}, 32'h0);
        @(posedge clk);
        #1 chk("lat_e2_l", {24'd0, l_level}, 32'h0);
        chk("lat_e2_valid", {31'd0, level_valid}, 32'h0);
        @(posedge clk);
        #1 chk("lat_e3_l", {24'd0, l_level}, 32'h80);
        chk("lat_e3_r", {24'd0, r_level}, 32'h0);
        chk("lat_e3_valid", {31'd0, level_valid}, 32'h1);
        @(posedge clk);
        #1 chk("lat_e4_valid", {31'd0, level_valid}, 32'h0);
        repeat (3) @(negedge clk);
        chk("lat_pulses", vcount - v0, 1);

        // A strobe landing in PROC_R is ignored.
        v0 = vcount;
        @(negedge clk);
        ls = 24'h000000;
        rs = 24'h000000;
        ace = 1'b1;
        sb.push_back('{8'h80, 8'h00});
        @(negedge clk);
        ace = 1'b0;
        @(posedge clk);
        #1 ls = 24'h7FFFFF;
        rs = 24'h7FFFFF;
        ace = 1'b1;
        @(posedge clk);
        #1 ace = 1'b0;
        repeat (8) @(negedge clk);
        chk("ign_pulses", vcount - v0, 1);
        chk("ign_l", {24'd0, l_level}, 32'h80);
        chk("ign_r", {24'd0, r_level}, 32'h0);

        // Reset asserted during PROC_L clears outputs at once; next strobe starts a clean frame.
        @(negedge clk);
        ls = 24'h400000;
        rs = 24'h400000;
        ace = 1'b1;
        @(posedge clk);
        #1 ace = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("abort_l", {24'd0, l_level}, 32'h0);
        chk("abort_r", {24'd0, r_level}, 32'h0);
        chk("abort_valid", {31'd0, level_valid}, 32'h0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        v0 = vcount;
        strobe(24'h200000, 24'h000000, 1'b1, 8'h40, 8'h00);
        @(negedge clk);
        chk("abort_next_pulses", vcount - v0, 1);
        chk("abort_next_l", {24'd0, l_level}, 32'h40);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            strobe(vt[i].l, vt[i].r, vt[i].en, vt[i].el, vt[i].er);
            chk($sformatf("vec%0d_l", i), {24'd0, l_level}, {24'd0, vt[i].el});
            chk($sformatf("vec%0d_r", i), {24'd0, r_level}, {24'd0, vt[i].er});
        end

        do_reset();
`ifdef VU_PEAK_HOLD_EN
        strobe(24'h400000, 24'h000000, 1'b1, 8'h80, 8'h00);
        for (int f = 2; f <= 4992; f++) begin
            strobe(24'h7FFFFF, 24'h7FFFFF, 1'b0,
                   (f < 4896) ? 8'h80 : (f < 4992) ? 8'h7F : 8'h7E, 8'h00);
            if (f == 4895) chk("hold_4895_l", {24'd0, l_level}, 32'h80);
            if (f == 4896) chk("hold_4896_l", {24'd0, l_level}, 32'h7F);
        end
        chk("hold_end_l", {24'd0, l_level}, 32'h7E);
        chk("hold_end_r", {24'd0, r_level}, 32'h0);
`else
        strobe(24'h400000, 24'hFF8000, 1'b1, 8'h80, 8'h01);
        for (int f = 2; f <= 288; f++) begin
            strobe((f <= 192) ? 24'h000000 : 24'h7FFFFF, (f <= 192) ? 24'h000000 : 24'h7FFFFF,
                   f <= 192,
                   (f < 96) ? 8'h80 : (f < 192) ? 8'h7F : (f < 288) ? 8'h7E : 8'h7D,
                   (f < 96) ? 8'h01 : 8'h00);
            if (f == 95) chk("decay_95_l", {24'd0, l_level}, 32'h80);
            if (f == 96) chk("decay_96_l", {24'd0, l_level}, 32'h7F);
            if (f == 192) chk("decay_192_r", {24'd0, r_level}, 32'h0);
        end
        chk("decay_end_l", {24'd0, l_level}, 32'h7D);
        chk("decay_end_r", {24'd0, r_level}, 32'h0);
`endif

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vu_envelope_detector.md
# vu_envelope_detector

Converts the 96 kHz signed left/right audio sample stream into 8-bit unsigned VU drive levels for the front-panel VU meter PWM driver. It full-wave rectifies each channel, applies instant attack with slow linear decay and an optional peak hold, and presents registered 8-bit levels that are stable between updates. It sits directly upstream of the VU meter PWM stage and feeds its left/right 8-bit level inputs.

## Interface
Parameters:
- SAMPLE_W, 24: width of signed input samples; must be ≥ 9.
- DECAY_DIV, 96: number of audio strobes per decay tick (1 ms at 96 kHz).
- DECAY_STEP, 1: amount subtracted from an envelope per decay tick.
- HOLD_SAMPLES, 4800: peak-hold length in strobes. Used only with `VU_PEAK_HOLD_EN`.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- audio_clk_enable  in  1  one-clk-wide 96 kHz sample strobe.
- audio_enable  in  1  1 = music playing. 0 = inputs treated as zero.
- l_sample  in  SAMPLE_W  signed two's-complement left sample, valid with the strobe.
- r_sample  in  SAMPLE_W  signed two's-complement right sample, valid with the strobe.
- l_level  out  8  left VU level.
- r_level  out  8  right VU level.
- level_valid  out  1  one-clk strobe when both levels have been updated.

## Operation
- FSM states: IDLE, PROC_L, PROC_R, UPDATE.
  - IDLE → PROC_L on a clk edge where audio_clk_enable=1. On that edge:
    - latch l_sample and r_sample, or latch zeros when audio_enable=0;
    - advance the decay counter;
    - latch the decay-tick flag.
  - PROC_L → PROC_R: compute the left envelope.
  - PROC_R → UPDATE: compute the right envelope.
  - UPDATE → IDLE: copy both envelopes to l_level and r_level, and assert level_valid for this one cycle.
- A strobe that arrives outside IDLE is ignored. It does not advance the decay counter. Requirement: clk ≥ 5× the strobe rate.
- Rectification: mag = |sample|. The most negative value (−2^(SAMPLE_W−1)) saturates to 2^(SAMPLE_W−1)−1. The 8-bit magnitude is mag[SAMPLE_W−2 : SAMPLE_W−9], i.e. truncation with no rounding.
- Decay counter:
  - counts 0..DECAY_DIV−1 and increments on each accepted strobe;
  - tick = 1 for a frame whose strobe sees counter == DECAY_DIV−1, and the counter then wraps to 0.
- Envelope update, per channel, in priority order:
  1. If mag8 ≥ env: env ← mag8 (instant attack).
  2. Else if tick (and the hold has expired): env ← max(env − DECAY_STEP, 0), saturating at 0 with no wrap.
  3. Else env is unchanged.
- Left and right envelopes are fully independent. Only the decay counter is shared.
- Reset values: FSM IDLE; envelopes, l_level, r_level, decay counter and hold counters 0; level_valid 0.
- reset_n asserted mid-frame aborts the frame immediately and applies the reset values. The first strobe after release starts a clean frame.

## Timing
- Strobe sampled at edge E0.
- Envelopes are computed at E1 (left) and E2 (right).
- l_level and r_level change at E3, and level_valid is high during the cycle following E3.
- End-to-end latency is 3 clk edges. Outputs hold their value between updates.
- A strobe occurring on the same edge as the UPDATE→IDLE transition is ignored, because the FSM is not yet in IDLE.

## Configuration
- `VU_PEAK_HOLD_EN` defined:
  - each channel has a hold counter that clears to 0 whenever an attack condition occurs (mag8 ≥ env);
  - the counter increments on every accepted strobe otherwise, saturating at HOLD_SAMPLES;
  - decay is applied only when hold counter == HOLD_SAMPLES and tick = 1.
- `VU_PEAK_HOLD_EN` undefined: no hold counters, and decay is applied on every tick.

## Test plan
- Reset, then one strobe with l_sample=0x400000 and r_sample=0x000000 → l_level=0x80 and r_level=0x00 three edges after the strobe; level_valid pulses exactly once.
- l_sample=0x800000 (most negative) → l_level=0xFF. r_sample=0xFF8000 (−32768) → r_level=0x01.
- No hold (`VU_PEAK_HOLD_EN` undefined): after reset, strobe 1 loads L=0x400000, strobes 2..96 carry zero → l_level stays 0x80 through strobe 95 and becomes 0x7F after strobe 96.
- Hold (`VU_PEAK_HOLD_EN` defined, HOLD_SAMPLES=4800): load 0x80, then send zero samples → l_level stays 0x80 until the first tick at which hold counter=4800, then decays by 1 per 96 strobes and reaches 0x00, never wrapping.
- audio_enable=0 with full-scale inputs → levels do not rise and the existing envelope keeps decaying. Also pulse a second strobe during PROC_R → it is ignored and only one level_valid is produced.
- Assert reset_n during PROC_L with nonzero levels → l_level, r_level and level_valid are 0 immediately, and the FSM is in IDLE after release.
